// File: rtl/mfp_ahb_lite_cmd_master_pkg.sv
// Shared AHB-Lite encodings and pipeline stage records for the command master.
package mfp_ahb_lite_cmd_master_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE     = 3'b000,
    HSIZE_HALFWORD = 3'b001,
    HSIZE_WORD     = 3'b010
  } hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // Address-phase slot; an illegal entry is a bubble that is never put on the bus.
  typedef struct packed {
    logic        valid;
    logic        illegal;
    logic [31:0] addr;
    logic        write;
    logic [1:0]  size;
    logic [31:0] wdata;
  } ap_t;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic        local_err;
    logic [31:0] wdata;
  } dp_t;

endpackage

// File: rtl/mfp_ahb_lite_cmd_master_if.sv
// AHB-Lite bus bundle and the requester command/response bundle.
// cmd: a command transfers on a rising edge where cmd_valid && cmd_ready;
// the requester holds cmd_* stable while cmd_valid is high and not yet accepted.
// rsp: rsp_valid is a single-cycle pulse with no backpressure.
interface mfp_ahb_lite_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HPROT, HWDATA,
    input  HRDATA, HREADY, HRESP
  );
  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HPROT, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

interface mfp_cmd_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error
  );
  modport slave (
    input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/mfp_ahb_lite_cmd_master.sv
// AHB-Lite initiator: single read/write commands become pipelined SINGLE transfers,
// one in-order response per command, with a two-stage (address/data phase) pipeline.
module mfp_ahb_lite_cmd_master
  import mfp_ahb_lite_cmd_master_pkg::*;
#(
  parameter logic [3:0] HPROT_VALUE = 4'b0011
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  mfp_ahb_lite_if.master ahb,
  mfp_cmd_if.slave       cmd
);

  function automatic logic cmd_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
    case ({1'b0, size})
      HSIZE_BYTE:     return 1'b0;
      HSIZE_HALFWORD: return addr_lo[0];
      HSIZE_WORD:     return addr_lo != 2'b00;
      default:        return 1'b1;
    endcase
  endfunction

  ap_t         ap_q, ap_d;
  dp_t         dp_q, dp_d;
  logic        cancel_q, cancel_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_error_q, rsp_error_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic cmd_ready;
  logic accept;
  logic illegal;
  logic ap_adv;
  logic direct_dp;
  ap_t  new_ap;

  always_comb begin
    cmd_ready = !ahb.HRESP && (!ap_q.valid || ahb.HREADY);
    accept    = cmd.cmd_valid && cmd_ready;
    illegal   = cmd_illegal(cmd.cmd_size, cmd.cmd_addr[1:0]);
    // A cancelled AP (first error cycle) was not seen by the slave, so it must not advance.
    ap_adv    = ap_q.valid && !cancel_q;
    // An illegal command skips the address phase when nothing is ahead of it in AP.
    direct_dp = accept && illegal && !ap_q.valid && ahb.HREADY;
    new_ap    = '{valid: 1'b1, illegal: illegal, addr: cmd.cmd_addr, write: cmd.cmd_write,
                  size: cmd.cmd_size, wdata: cmd.cmd_wdata};

    ap_d        = ap_q;
    dp_d        = dp_q;
    cancel_d    = ahb.HRESP && !ahb.HREADY;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    rsp_rdata_d = '0;

    if (ahb.HREADY) begin
      rsp_valid_d = dp_q.valid;
      rsp_error_d = dp_q.valid && (ahb.HRESP || dp_q.local_err);
      if (dp_q.valid && !dp_q.write && !rsp_error_d) rsp_rdata_d = ahb.HRDATA;
      dp_d.valid = 1'b0;
      if (ap_adv) begin
        dp_d       = '{valid: 1'b1, write: ap_q.write, local_err: ap_q.illegal, wdata: ap_q.wdata};
        ap_d.valid = 1'b0;
      end else if (direct_dp) begin
        dp_d = '{valid: 1'b1, write: cmd.cmd_write, local_err: 1'b1, wdata: cmd.cmd_wdata};
      end
    end

    if (accept && !direct_dp) ap_d = new_ap;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_q        <= '0;
      dp_q        <= '0;
      cancel_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      ap_q        <= ap_d;
      dp_q        <= dp_d;
      cancel_q    <= cancel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign ahb.HADDR     = ap_q.addr;
  assign ahb.HTRANS    = (ap_adv && !ap_q.illegal) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahb.HWRITE    = ap_q.write;
  assign ahb.HSIZE     = {1'b0, ap_q.size};
  assign ahb.HBURST    = HBURST_SINGLE;
  assign ahb.HMASTLOCK = 1'b0;
  assign ahb.HPROT     = HPROT_VALUE;
  assign ahb.HWDATA    = dp_q.wdata;

  assign cmd.cmd_ready = cmd_ready;
  assign cmd.rsp_valid = rsp_valid_q;
  assign cmd.rsp_error = rsp_error_q;
  assign cmd.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mfp_ahb_lite_cmd_master.sv
// Directed bench for mfp_ahb_lite_cmd_master: scripted AHB slave, response scoreboard
// with expected arrival cycle, and a bus log of issued NONSEQ address phases.
module tb_mfp_ahb_lite_cmd_master;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  mfp_ahb_lite_if ahb ();
  mfp_cmd_if      cmd ();

  mfp_ahb_lite_cmd_master #(.HPROT_VALUE(4'b0011)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .ahb     (ahb),
    .cmd     (cmd)
  );

  // ---------------- clock / reset ----------------
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [48:0] exp_q[$];       // {arrival cycle[15:0], error, rdata}
  logic [47:0] bus_log[$];     // {cycle[15:0], HADDR} of each accepted NONSEQ
  int          plan_waits[$];
  bit          plan_err[$];
  logic [31:0] plan_rdata[$];
  logic [48:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic plan(input int waits, input bit err, input logic [31:0] rdata);
    plan_waits.push_back(waits);
    plan_err.push_back(err);
    plan_rdata.push_back(rdata);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  // ---------------- AHB slave model ----------------
  initial begin : slave
    bit take;
    bit done;
    bit sl_busy;
    bit sl_err;
    bit sl_err_step;
    int sl_wait;
    logic [31:0] sl_rdata;
    ahb.HREADY = 1'b1;
    ahb.HRESP  = 1'b0;
    ahb.HRDATA = '0;
    sl_busy = 0; sl_err = 0; sl_err_step = 0; sl_wait = 0; sl_rdata = '0;
    forever begin
      @(negedge HCLK);
      take = (ahb.HTRANS == 2'b10) && ahb.HREADY && HRESETn;
      done = ahb.HREADY;
      @(posedge HCLK);
      #1;
      if (!HRESETn) begin
        sl_busy = 0;
        ahb.HREADY = 1'b1; ahb.HRESP = 1'b0; ahb.HRDATA = '0;
        continue;
      end
      if (done) begin
        sl_busy = take;
        if (take) begin
          if (plan_waits.size() > 0) begin
            sl_wait  = plan_waits.pop_front();
            sl_err   = plan_err.pop_front();
            sl_rdata = plan_rdata.pop_front();
          end else begin
            sl_wait = 0; sl_err = 0; sl_rdata = 32'hFFFF_FFFF;
          end
          sl_err_step = 0;
        end
      end
      ahb.HRESP  = 1'b0;
      ahb.HRDATA = '0;
      if (!sl_busy) begin
        ahb.HREADY = 1'b1;
      end else if (sl_err) begin
        ahb.HRESP   = 1'b1;
        ahb.HREADY  = sl_err_step;
        sl_err_step = 1;
      end else if (sl_wait > 0) begin
        ahb.HREADY = 1'b0;
        sl_wait--;
      end else begin
        ahb.HREADY = 1'b1;
        ahb.HRDATA = sl_rdata;
      end
    end
  end

  // ---------------- monitors ----------------
  always @(negedge HCLK) begin
    if (HRESETn && cmd.rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid with no pending command (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_cycle", {16'h0, cyc[15:0]}, {16'h0, mon_e[48:33]});
        chk("rsp_error", {31'h0, cmd.rsp_error}, {31'h0, mon_e[32]});
        chk("rsp_rdata", cmd.rsp_rdata, mon_e[31:0]);
      end
    end
  end

  always @(negedge HCLK) begin
    if (HRESETn && ahb.HTRANS == 2'b10 && ahb.HREADY) bus_log.push_back({cyc[15:0], ahb.HADDR});
  end

  // ---------------- driver ----------------
  task automatic send_cmd(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                          input logic [31:0] wdata, input int lat, input logic exp_err,
                          input logic [31:0] exp_rdata, output int acc);
    bit fire;
    fire = 0;
    acc  = -1;
    cmd.cmd_addr  = addr;
    cmd.cmd_write = wr;
    cmd.cmd_size  = size;
    cmd.cmd_wdata = wdata;
    cmd.cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !fire; i++) begin
      @(negedge HCLK);
      fire = cmd.cmd_ready;
      @(posedge HCLK);
      #1;
    end
    cmd.cmd_valid = 1'b0;
    if (!fire) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no acceptance for addr %h expected acceptance", addr);
    end else begin
      acc = cyc;
      exp_q.push_back({16'(acc + lat), exp_err, exp_rdata});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int a0, a1, a2, a3;
    logic [47:0] le;
    cmd.cmd_valid = 1'b0;
    cmd.cmd_addr  = '0;
    cmd.cmd_write = 1'b0;
    cmd.cmd_size  = 2'd0;
    cmd.cmd_wdata = '0;

    // reset state
    repeat (2) @(negedge HCLK);
    chk("rst_htrans", {30'h0, ahb.HTRANS}, 32'h0);
    chk("rst_haddr", ahb.HADDR, 32'h0);
    chk("rst_hwdata", ahb.HWDATA, 32'h0);
    chk("rst_hsize", {29'h0, ahb.HSIZE}, 32'h0);
    chk("rst_hwrite", {31'h0, ahb.HWRITE}, 32'h0);
    chk("rst_rsp", {cmd.rsp_rdata[30:0], cmd.rsp_valid} | {31'h0, cmd.rsp_error}, 32'h0);
    chk("rst_cmd_ready", {31'h0, cmd.cmd_ready}, 32'h1);
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    idle(2);

    // zero-wait word write
    plan(0, 0, 32'h0);
    send_cmd(32'h1F80_0000, 1'b1, 2'd2, 32'hA5A5_0F0F, 2, 1'b0, 32'h0, a0);
    @(negedge HCLK);
    chk("w_htrans", {30'h0, ahb.HTRANS}, 32'h2);
    chk("w_haddr", ahb.HADDR, 32'h1F80_0000);
    chk("w_hwrite", {31'h0, ahb.HWRITE}, 32'h1);
    chk("w_hsize", {29'h0, ahb.HSIZE}, 32'h2);
    chk("w_hburst", {29'h0, ahb.HBURST}, 32'h0);
    chk("w_hprot", {28'h0, ahb.HPROT}, 32'h3);
    chk("w_hmastlock", {31'h0, ahb.HMASTLOCK}, 32'h0);
    @(negedge HCLK);
    chk("w_hwdata", ahb.HWDATA, 32'hA5A5_0F0F);
    chk("w_htrans_dp", {30'h0, ahb.HTRANS}, 32'h0);
    idle(4);

    // read with three wait states
    plan(3, 0, 32'h0000_00C3);
    send_cmd(32'h1F80_0008, 1'b0, 2'd2, 32'h0, 5, 1'b0, 32'h0000_00C3, a0);
    @(negedge HCLK);
    chk("rw_htrans", {30'h0, ahb.HTRANS}, 32'h2);
    chk("rw_haddr", ahb.HADDR, 32'h1F80_0008);
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      chk("rw_wait_haddr", ahb.HADDR, 32'h1F80_0008);
      chk("rw_wait_htrans", {30'h0, ahb.HTRANS}, 32'h0);
      chk("rw_wait_hwdata", ahb.HWDATA, 32'h0);
    end
    idle(4);

    // four back-to-back commands
    bus_log.delete();
    plan(0, 0, 32'h0);
    plan(0, 0, 32'hDEAD_0001);
    plan(0, 0, 32'h0);
    plan(0, 0, 32'h0000_BEEF);
    send_cmd(32'h1F80_0010, 1'b1, 2'd2, 32'h1111_2222, 2, 1'b0, 32'h0, a0);
    send_cmd(32'h1F80_0014, 1'b0, 2'd2, 32'h0, 2, 1'b0, 32'hDEAD_0001, a1);
    send_cmd(32'h1F80_0018, 1'b1, 2'd1, 32'h3333_4444, 2, 1'b0, 32'h0, a2);
    send_cmd(32'h1F80_001C, 1'b0, 2'd0, 32'h0, 2, 1'b0, 32'h0000_BEEF, a3);
    idle(5);
    chk("b2b_gap1", 32'(a1 - a0), 32'd1);
    chk("b2b_gap2", 32'(a2 - a1), 32'd1);
    chk("b2b_gap3", 32'(a3 - a2), 32'd1);
    chk("b2b_nonseq_count", 32'(bus_log.size()), 32'd4);
    if (bus_log.size() == 4) begin
      chk("b2b_addr0", bus_log[0][31:0], 32'h1F80_0010);
      chk("b2b_addr3", bus_log[3][31:0], 32'h1F80_001C);
      chk("b2b_cyc0", {16'h0, bus_log[0][47:32]}, 32'(a0 & 16'hFFFF));
      chk("b2b_cyc3", {16'h0, bus_log[3][47:32]}, 32'(a3 & 16'hFFFF));
    end

    // ERROR on a write followed by a read
    bus_log.delete();
    plan(0, 1, 32'h0);
    plan(0, 0, 32'h0000_5A5A);
    send_cmd(32'h1F80_0020, 1'b1, 2'd2, 32'hCAFE_F00D, 3, 1'b1, 32'h0, a0);
    send_cmd(32'h1F80_0024, 1'b0, 2'd2, 32'h0, 4, 1'b0, 32'h0000_5A5A, a1);
    @(negedge HCLK);
    chk("err1_cmd_ready", {31'h0, cmd.cmd_ready}, 32'h0);
    @(negedge HCLK);
    chk("err2_htrans", {30'h0, ahb.HTRANS}, 32'h0);
    chk("err2_cmd_ready", {31'h0, cmd.cmd_ready}, 32'h0);
    idle(5);
    chk("err_accept_gap", 32'(a1 - a0), 32'd1);
    chk("err_nonseq_count", 32'(bus_log.size()), 32'd2);
    if (bus_log.size() == 2) begin
      le = bus_log[1];
      chk("err_retry_addr", le[31:0], 32'h1F80_0024);
      chk("err_retry_cyc", {16'h0, le[47:32]}, 32'((a0 + 3) & 16'hFFFF));
    end

    // illegal commands: misaligned halfword, size 3, misaligned word
    bus_log.delete();
    send_cmd(32'h1F80_0041, 1'b1, 2'd1, 32'h0000_1234, 1, 1'b1, 32'h0, a0);
    send_cmd(32'h1F80_0044, 1'b0, 2'd3, 32'h0, 1, 1'b1, 32'h0, a1);
    send_cmd(32'h1F80_0046, 1'b1, 2'd2, 32'h5555_AAAA, 1, 1'b1, 32'h0, a2);
    idle(4);
    chk("ill_nonseq_count", 32'(bus_log.size()), 32'd0);

    // reset while a read is in its data phase and a write sits in AP
    plan(2, 0, 32'h0000_0077);
    send_cmd(32'h1F80_0030, 1'b0, 2'd2, 32'h0, 4, 1'b0, 32'h0000_0077, a0);
    send_cmd(32'h1F80_0034, 1'b1, 2'd2, 32'h9999_0000, 4, 1'b0, 32'h0, a1);
    @(negedge HCLK);
    chk("prerst_htrans", {30'h0, ahb.HTRANS}, 32'h2);
    chk("prerst_cmd_ready", {31'h0, cmd.cmd_ready}, 32'h0);
    #1 HRESETn = 1'b0;
    exp_q.delete();
    plan_waits.delete();
    plan_err.delete();
    plan_rdata.delete();
    #1;
    chk("rst_mid_htrans", {30'h0, ahb.HTRANS}, 32'h0);
    chk("rst_mid_cmd_ready", {31'h0, cmd.cmd_ready}, 32'h1);
    @(posedge HCLK);
    #3 HRESETn = 1'b1;
    idle(8);

    // drain
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge HCLK);
    chk("drain_pending", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
